// File: rtl/multicycle_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_core : FSM-sequenced MIPS-subset core, one shared ALU,        |
// |                   32x32 register file, unified ready-handshake memory    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module multicycle_core #(
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic              retire,
   output logic              halted,
   output logic              fault
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   localparam logic [2:0] S_FAULT  = 3'd6;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SLT     = 6'h2A;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_SLT = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       alu_out_q, alu_out_d;
   logic [31:0]       mdr_q, mdr_d;
   logic [31:0]       rf_q [32];
   logic [31:0]       rf_d [32];

   logic              rf_we;
   logic [4:0]        rf_wa;
   logic [31:0]       rf_wd;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_se, imm_ze, pc_ext, jump_tgt;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm_se   = {{16{ir_q[15]}}, ir_q[15:0]};
   assign imm_ze   = {16'h0000, ir_q[15:0]};
   assign pc_ext   = 32'(pc_q);
   assign jump_tgt = {pc_ext[31:28], ir_q[25:0], 2'b00};

   logic is_r, is_alu_r, is_jr, is_sys, is_imm, is_load, is_store;
   logic is_branch, is_jump, legal;

   assign is_r      = (op == OP_RTYPE);
   assign is_alu_r  = is_r && (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
   assign is_jr     = is_r && (funct == FN_JR);
   assign is_sys    = is_r && (funct == FN_SYSCALL);
   assign is_imm    = (op == OP_ADDI) || (op == OP_XORI);
   assign is_load   = (op == OP_LW);
   assign is_store  = (op == OP_SW);
   assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
   assign is_jump   = (op == OP_J) || (op == OP_JAL);
   assign legal     = is_alu_r || is_jr || is_sys || is_imm || is_load ||
                      is_store || is_branch || is_jump;

   // Shared ALU: PC+4 in FETCH, branch target in DECODE, the instruction's op in EXEC
   logic [31:0] alu_a, alu_b, alu_y, alu_diff;
   logic [1:0]  alu_op;
   logic        alu_zero;

   always_comb begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            alu_a = pc_ext;
            alu_b = 32'd4;
         end
         S_DECODE: begin
            alu_a = pc_ext;
            alu_b = {imm_se[29:0], 2'b00};
         end
         S_EXEC: begin
            if (op == OP_XORI)
               alu_b = imm_ze;
            else if (is_imm || is_load || is_store)
               alu_b = imm_se;
            if (op == OP_XORI)
               alu_op = ALU_XOR;
            else if (is_branch || (is_r && funct == FN_SUB))
               alu_op = ALU_SUB;
            else if (is_r && funct == FN_SLT)
               alu_op = ALU_SLT;
         end
         default: ;
      endcase
   end

   always_comb begin
      alu_diff = alu_a - alu_b;
      alu_y    = alu_a + alu_b;
      case (alu_op)
         ALU_SUB: alu_y = alu_diff;
         ALU_SLT: alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
         ALU_XOR: alu_y = alu_a ^ alu_b;
         default: alu_y = alu_a + alu_b;
      endcase
      alu_zero = (alu_y == 32'd0);
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      mdr_d     = mdr_q;
      rf_we     = 1'b0;
      rf_wa     = 5'd0;
      rf_wd     = 32'd0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = alu_y[ADDR_W-1:0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d       = rf_q[rs];
            b_d       = rf_q[rt];
            alu_out_d = alu_y;
            if (!legal)
               state_d = S_FAULT;
            else if (is_sys)
               state_d = S_HALT;
            else
               state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (is_alu_r || is_imm) begin
               alu_out_d = alu_y;
               state_d   = S_WB;
            end else if (is_load || is_store) begin
               alu_out_d = alu_y;
               state_d   = (alu_y[1:0] != 2'b00) ? S_FAULT : S_MEM;
            end else if (is_branch) begin
               // alu_out_q still holds the target computed during DECODE
               if (alu_zero == (op == OP_BEQ))
                  pc_d = alu_out_q[ADDR_W-1:0];
            end else if (is_jump) begin
               pc_d = jump_tgt[ADDR_W-1:0];
               if (op == OP_JAL) begin
                  rf_we = 1'b1;
                  rf_wa = 5'd31;
                  rf_wd = pc_ext;
               end
            end else if (is_jr) begin
               pc_d = a_q[ADDR_W-1:0];
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               if (is_load) begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            rf_wa   = is_r ? rd : rt;
            rf_wd   = is_load ? mdr_q : alu_out_q;
            state_d = S_FETCH;
         end
         default: ;
      endcase
   end

   always_comb begin
      rf_d = rf_q;
      if (rf_we && rf_wa != 5'd0)
         rf_d[rf_wa] = rf_wd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC[ADDR_W-1:0];
         ir_q      <= 32'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         alu_out_q <= 32'd0;
         mdr_q     <= 32'd0;
         for (int i = 0; i < 32; i++)
            rf_q[i] <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         mdr_q     <= mdr_d;
         rf_q      <= rf_d;
      end
   end

   // Gating with reset drops mem_req immediately on an asynchronous reset
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = 32'd0;
      mem_addr  = {pc_q[ADDR_W-1:2], 2'b00};
      if (!reset) begin
         if (state_q == S_FETCH) begin
            mem_req = 1'b1;
         end else if (state_q == S_MEM) begin
            mem_req  = 1'b1;
            mem_we   = is_store;
            mem_addr = alu_out_q[ADDR_W-1:0];
            if (is_store)
               mem_wdata = b_q;
         end
      end
   end

   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_DECODE: retire = is_sys;
         S_EXEC:   retire = is_branch || is_jump || is_jr;
         S_MEM:    retire = is_store && mem_ready;
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
   end

   assign pc_out = pc_q;
   assign halted = (state_q == S_HALT);
   assign fault  = (state_q == S_FAULT);

endmodule
`default_nettype wire
